// File: rtl/async_rx_multi.sv
`default_nettype none
// ------------------------------------------------------------------------
// async_rx_multi: drains an FWFT FIFO of {channel, duty} words into
// per-channel duty registers, optionally double-buffered on period_sync.
// Optional clamp: ASYNC_RX_MULTI_CLAMP_EN.   Rev 1.0
// ------------------------------------------------------------------------
module async_rx_multi #(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 4,
  parameter int SYNC_UPDATE = 1,
  parameter int MAX_DUTY    = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_W+DATA_W-1:0]   data,
  input  logic                     empty,
  output logic                     r_en,
  input  logic                     hold,
  input  logic                     period_sync,
  output logic [NUM_CH*DATA_W-1:0] duty_cycle,
  output logic [NUM_CH-1:0]        updated,
  output logic [7:0]               err_cnt
);

  localparam int                WORD_W   = CH_W + DATA_W;
  localparam logic [DATA_W-1:0] MAX_VAL  = DATA_W'(MAX_DUTY);
  localparam logic [CH_W:0]     NUM_CH_C = (CH_W+1)'(NUM_CH);
`ifdef ASYNC_RX_MULTI_CLAMP_EN
  localparam bit                CLAMP_EN = 1'b1;
`else
  localparam bit                CLAMP_EN = 1'b0;
`endif

  logic                           pop;
  logic [WORD_W-1:0]              cap_word_q, cap_word_d;
  logic                           cap_valid_q, cap_valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  active_q, active_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [NUM_CH-1:0]              updated_q, updated_d;
  logic [7:0]                     err_cnt_q, err_cnt_d;

  logic [CH_W-1:0]                cap_ch;
  logic [DATA_W-1:0]              cap_val;
  logic [DATA_W-1:0]              wr_val;
  logic                           in_range;

  assign pop  = rst & ~empty & ~hold;
  assign r_en = pop;

  assign cap_ch   = cap_word_q[WORD_W-1:DATA_W];
  assign cap_val  = cap_word_q[DATA_W-1:0];
  assign in_range = ({1'b0, cap_ch} < NUM_CH_C);
  assign wr_val   = (CLAMP_EN && (cap_val > MAX_VAL)) ? MAX_VAL : cap_val;

  always_comb begin
    cap_valid_d = pop;
    cap_word_d  = pop ? data : cap_word_q;
  end

  // Period load is evaluated before the stage-2 write so that a colliding
  // write lands in the shadow and stays pending for the next period.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    updated_d = '0;
    err_cnt_d = err_cnt_q;
    if (SYNC_UPDATE != 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (period_sync && pending_q[k]) begin
          active_d[k]  = shadow_q[k];
          pending_d[k] = 1'b0;
          updated_d[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (cap_valid_q && in_range && (cap_ch == CH_W'(k))) begin
        if (SYNC_UPDATE != 0) begin
          shadow_d[k]  = wr_val;
          pending_d[k] = 1'b1;
        end else begin
          active_d[k]  = wr_val;
          updated_d[k] = 1'b1;
        end
      end
    end
    if (cap_valid_q && !in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_word_q  <= '0;
      cap_valid_q <= 1'b0;
      active_q    <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      updated_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      cap_word_q  <= cap_word_d;
      cap_valid_q <= cap_valid_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      updated_q   <= updated_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign duty_cycle[g*DATA_W +: DATA_W] = active_q[g];
    end
  endgenerate

  assign updated = updated_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_async_rx_multi.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_async_rx_multi: directed bench with a direct-write and a
// double-buffered instance sharing one FIFO stimulus.   Rev 1.0
// ------------------------------------------------------------------------
module tb_async_rx_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = '0;
  logic        empty = 1'b1;
  logic        hold = 1'b0;
  logic        period_sync = 1'b0;

  logic        r_en0, r_en1;
  logic [47:0] duty0, duty1;
  logic [3:0]  upd0, upd1;
  logic [7:0]  err0, err1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  async_rx_multi #(.DATA_W(12), .NUM_CH(4), .CH_W(4), .SYNC_UPDATE(0), .MAX_DUTY(1000)) u_dut0 (
    .clk(clk), .rst(rst), .data(data), .empty(empty), .r_en(r_en0), .hold(hold),
    .period_sync(period_sync), .duty_cycle(duty0), .updated(upd0), .err_cnt(err0)
  );

  async_rx_multi #(.DATA_W(12), .NUM_CH(4), .CH_W(4), .SYNC_UPDATE(1), .MAX_DUTY(1000)) u_dut1 (
    .clk(clk), .rst(rst), .data(data), .empty(empty), .r_en(r_en1), .hold(hold),
    .period_sync(period_sync), .duty_cycle(duty1), .updated(upd1), .err_cnt(err1)
  );

  function automatic logic [11:0] ch_of(input logic [47:0] v, input int k);
    return v[k*12 +: 12];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; empty = 1'b1; hold = 1'b0; period_sync = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Presents one word for exactly one pop edge; returns on the negedge after it.
  task automatic send_word(input logic [3:0] ch, input logic [11:0] val);
    data = {ch, val};
    empty = 1'b0;
    @(negedge clk);
    empty = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; empty = 1'b0; data = {4'd1, 12'h555};
    repeat (3) @(negedge clk);
    checks++;
    if (r_en0 !== 1'b0 || r_en1 !== 1'b0) begin
      failures++; $display("FAIL reset_r_en: got %b/%b want 0/0", r_en0, r_en1);
    end
    checks++;
    if (duty0 !== 48'h0 || duty1 !== 48'h0 || err0 !== 8'h0 || err1 !== 8'h0) begin
      failures++; $display("FAIL reset_regs: duty %h/%h err %0d/%0d want 0", duty0, duty1, err0, err1);
    end
    checks++;
    if (upd0 !== 4'b0 || upd1 !== 4'b0) begin
      failures++; $display("FAIL reset_updated: got %b/%b want 0000", upd0, upd1);
    end
    empty = 1'b1;
    rst = 1'b1;
  endtask

  task automatic test_direct_write();
    do_reset();
    @(negedge clk);
    data = {4'd2, 12'h3A5}; empty = 1'b0;
    #1;
    checks++;
    if (r_en0 !== 1'b1) begin
      failures++; $display("FAIL direct_r_en: got %b want 1", r_en0);
    end
    @(negedge clk);
    empty = 1'b1;
    checks++;
    if (duty0 !== 48'h0) begin
      failures++; $display("FAIL direct_early: got %h want 0", duty0);
    end
    @(negedge clk);
    checks++;
    if (duty0 !== {12'h0, 12'h3A5, 12'h0, 12'h0} || upd0 !== 4'b0100) begin
      failures++; $display("FAIL direct_write: duty %h upd %b want 0003a5000000 0100", duty0, upd0);
    end
    checks++;
    if (duty1 !== 48'h0 || upd1 !== 4'b0) begin
      failures++; $display("FAIL direct_shadow_only: duty %h upd %b want 0 0000", duty1, upd1);
    end
    @(negedge clk);
    checks++;
    if (upd0 !== 4'b0 || ch_of(duty0, 2) !== 12'h3A5) begin
      failures++; $display("FAIL direct_pulse_end: upd %b duty2 %h want 0000 3a5", upd0, ch_of(duty0, 2));
    end
  endtask

  task automatic test_sync_update();
    do_reset();
    @(negedge clk);
    data = {4'd0, 12'h100}; empty = 1'b0;
    @(negedge clk);
    data = {4'd1, 12'h200};
    @(negedge clk);
    empty = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (duty1 !== 48'h0 || upd1 !== 4'b0) begin
      failures++; $display("FAIL sync_before: duty %h upd %b want 0 0000", duty1, upd1);
    end
    period_sync = 1'b1;
    @(negedge clk);
    period_sync = 1'b0;
    checks++;
    if (ch_of(duty1, 0) !== 12'h100 || ch_of(duty1, 1) !== 12'h200 || upd1 !== 4'b0011) begin
      failures++; $display("FAIL sync_load: ch0 %h ch1 %h upd %b want 100 200 0011",
                           ch_of(duty1, 0), ch_of(duty1, 1), upd1);
    end
    @(negedge clk);
    period_sync = 1'b1;
    @(negedge clk);
    period_sync = 1'b0;
    checks++;
    if (upd1 !== 4'b0 || ch_of(duty1, 0) !== 12'h100) begin
      failures++; $display("FAIL sync_no_pending: upd %b ch0 %h want 0000 100", upd1, ch_of(duty1, 0));
    end
    checks++;
    if (ch_of(duty0, 0) !== 12'h100 || ch_of(duty0, 1) !== 12'h200) begin
      failures++; $display("FAIL sync_ignored_direct: ch0 %h ch1 %h want 100 200", ch_of(duty0, 0), ch_of(duty0, 1));
    end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    send_word(4'd1, 12'h050);
    @(negedge clk);
    send_word(4'd1, 12'h060);
    period_sync = 1'b1;
    @(negedge clk);
    period_sync = 1'b0;
    checks++;
    if (ch_of(duty1, 1) !== 12'h050 || upd1 !== 4'b0010) begin
      failures++; $display("FAIL collision_load: ch1 %h upd %b want 050 0010", ch_of(duty1, 1), upd1);
    end
    repeat (2) @(negedge clk);
    period_sync = 1'b1;
    @(negedge clk);
    period_sync = 1'b0;
    checks++;
    if (ch_of(duty1, 1) !== 12'h060 || upd1 !== 4'b0010) begin
      failures++; $display("FAIL collision_next: ch1 %h upd %b want 060 0010", ch_of(duty1, 1), upd1);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk);
    data = {4'd7, 12'h123}; empty = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (err0 !== 8'd9 || err1 !== 8'd9) begin
      failures++; $display("FAIL err_count: got %0d/%0d want 9", err0, err1);
    end
    repeat (290) @(negedge clk);
    empty = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (err0 !== 8'd255 || err1 !== 8'd255) begin
      failures++; $display("FAIL err_saturate: got %0d/%0d want 255", err0, err1);
    end
    checks++;
    if (duty0 !== 48'h0 || duty1 !== 48'h0 || upd0 !== 4'b0) begin
      failures++; $display("FAIL err_no_write: duty %h/%h upd %b want 0", duty0, duty1, upd0);
    end
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    hold = 1'b1; data = {4'd0, 12'h0AA}; empty = 1'b0;
    #1;
    checks++;
    if (r_en0 !== 1'b0) begin
      failures++; $display("FAIL hold_r_en: got %b want 0", r_en0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (duty0 !== 48'h0) begin
      failures++; $display("FAIL hold_no_capture: got %h want 0", duty0);
    end
    hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    data = {4'd0, 12'h0BB};
    @(negedge clk);
    checks++;
    if (ch_of(duty0, 0) !== 12'h0AA) begin
      failures++; $display("FAIL hold_drain_inflight: got %h want 0aa", ch_of(duty0, 0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ch_of(duty0, 0) !== 12'h0AA || upd0 !== 4'b0) begin
      failures++; $display("FAIL hold_stalled: ch0 %h upd %b want 0aa 0000", ch_of(duty0, 0), upd0);
    end
    hold = 1'b0; empty = 1'b1;
  endtask

  task automatic test_clamp();
    logic [11:0] exp_val;
`ifdef ASYNC_RX_MULTI_CLAMP_EN
    exp_val = 12'd1000;
`else
    exp_val = 12'hFFF;
`endif
    do_reset();
    @(negedge clk);
    send_word(4'd3, 12'hFFF);
    @(negedge clk);
    checks++;
    if (ch_of(duty0, 3) !== exp_val) begin
      failures++; $display("FAIL clamp_ch3: got %h want %h", ch_of(duty0, 3), exp_val);
    end
    send_word(4'd3, 12'd900);
    @(negedge clk);
    checks++;
    if (ch_of(duty0, 3) !== 12'd900) begin
      failures++; $display("FAIL clamp_in_range: got %0d want 900", ch_of(duty0, 3));
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    data = {4'd1, 12'h777}; empty = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (r_en0 !== 1'b0) begin
      failures++; $display("FAIL midreset_r_en: got %b want 0", r_en0);
    end
    @(negedge clk);
    empty = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (duty0 !== 48'h0 || upd0 !== 4'b0) begin
      failures++; $display("FAIL midreset_discard: duty %h upd %b want 0 0000", duty0, upd0);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_sync_update();
    test_collision();
    test_out_of_range();
    test_hold();
    test_clamp();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/async_rx_multi.md
Name: async_rx_multi

Overview:
- Multi-channel successor to the single-channel PWM duty-cycle receiver.
- Drains a first-word-fall-through (FWFT) async FIFO read port. Each FIFO word carries a channel index and a duty value.
- Holds one duty-cycle register per channel, optionally double-buffered so updates land only on a PWM period boundary.
- Sits between the CPU-side clock-crossing FIFO and the PWM generators, in the PWM clock domain.

Parameters:
- DATA_W, 12, duty value width.
- NUM_CH, 4, number of duty channels (1..16).
- CH_W, 4, channel index field width in the FIFO word; must satisfy 2^CH_W >= NUM_CH.
- SYNC_UPDATE, 1, 1 = shadow/active double buffer loaded on period_sync; 0 = active register written directly.
- MAX_DUTY, 4095, clamp ceiling, used only with the optional feature.

Ports:
- clk  in  1  single clock (PWM domain).
- rst  in  1  synchronous, active-low reset.
- data  in  CH_W+DATA_W  FIFO read data, FWFT; [CH_W+DATA_W-1:DATA_W] = channel, [DATA_W-1:0] = value.
- empty  in  1  FIFO empty; data is valid when empty=0.
- r_en  out  1  FIFO pop.
- hold  in  1  1 = stop draining the FIFO.
- period_sync  in  1  one-cycle pulse at PWM period start.
- duty_cycle  out  NUM_CH*DATA_W  active duty values; channel k at [k*DATA_W +: DATA_W].
- updated  out  NUM_CH  one-cycle pulse per channel when its active value is loaded.
- err_cnt  out  8  saturating count of words dropped for an out-of-range channel.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Cleared: duty_cycle, updated, err_cnt, all shadow registers, pending flags, capture register and capture valid.
  - r_en held 0 combinationally while rst=0.
- Pop rule:
  - r_en = rst & ~empty & ~hold (combinational).
  - The word on data is taken in the cycle r_en=1.
  - Up to one pop per cycle, sustained back-to-back.
- Stage 1 (edge ending pop cycle N):
  - cap_word <= data; cap_valid <= 1.
  - cap_valid <= 0 when no pop occurs.
- Stage 2, in cycle N+1 when cap_valid=1:
  - ch >= NUM_CH: word dropped, no register written, err_cnt += 1, saturating at 255.
  - SYNC_UPDATE=0: active[ch] <= value and updated[ch] pulses. New value visible in cycle N+2.
  - SYNC_UPDATE=1: shadow[ch] <= value and pending[ch] <= 1. Shadow visible in cycle N+2; no updated pulse yet.
- Period load (SYNC_UPDATE=1), at the edge of a cycle with period_sync=1:
  - Every channel with pending=1 loads active <= shadow, clears pending, and pulses updated for one cycle (visible the next cycle).
  - Channels with pending=0 are unchanged.
- Simultaneous shadow write and period_sync on the same channel:
  - Active loads the pre-write shadow value; updated pulses.
  - Shadow takes the new value; pending stays 1, so the new value loads at the next period_sync.
- Multiple writes to one channel within a period: last value wins; only one load and one updated pulse occur.
- hold asserted: a word already in cap_word still completes stage 2; no new pops.
- Reset mid-operation: an in-flight capture is discarded; no further FIFO interaction until rst=1.
- period_sync is ignored when SYNC_UPDATE=0.

Optional Feature:
- Macro: ASYNC_RX_MULTI_CLAMP_EN.
- Defined: at stage 2, a value > MAX_DUTY is replaced by MAX_DUTY before the shadow/active write. In-range values pass unchanged.
- Undefined: the value is written unmodified and MAX_DUTY is unused.

Test Plan:
- Reset: hold rst=0 with empty=0 -> r_en=0; duty_cycle=0, err_cnt=0, updated=0.
- SYNC_UPDATE=0, single word {ch=2, 0x3A5} popped in cycle N -> duty_cycle[2]=0x3A5 from N+2; updated=4'b0100 for one cycle; other channels stay 0.
- SYNC_UPDATE=1, words to ch0=0x100, ch1=0x200 back-to-back, then period_sync -> duty_cycle unchanged until the sync edge; then ch0=0x100, ch1=0x200 and updated=4'b0011 for one cycle. A second sync with no new words gives no pulse.
- Collision:
  - Setup: shadow[1]=0x050 pending; the stage-2 write of 0x060 to ch1 coincides with period_sync.
  - Result: active[1]=0x050 with an updated pulse; the next period_sync loads 0x060.
- Out-of-range and hold:
  - ch=7 with NUM_CH=4, sent 300 times -> err_cnt saturates at 255; duty_cycle unchanged.
  - hold=1 with empty=0 -> r_en=0 and no new captures.
- Clamp, with ASYNC_RX_MULTI_CLAMP_EN and MAX_DUTY=1000:
  - Write 0xFFF to ch3 -> duty_cycle[3]=1000.
  - Without the macro -> duty_cycle[3]=0xFFF.
